// File: rtl/serial_adder_ctrl_pkg.sv
// Shared constants for the bit-serial add/subtract controller:
// FSM state encodings and the default operand width.
package serial_adder_ctrl_pkg;

  localparam int DEFAULT_WIDTH = 8;

  // 2-bit state encoding; the value 2'd3 is illegal and recovers to IDLE.
  typedef logic [1:0] state_t;

  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_RUN  = 2'd1;
  localparam state_t S_DONE = 2'd2;

endpackage : serial_adder_ctrl_pkg

// File: rtl/full_adder.sv
// Single-bit full adder cell shared by the serial controller.
module full_adder (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic Sum,
  output logic Cout
);

  assign Sum  = A ^ B ^ Cin;
  assign Cout = (A & B) | (Cin & (A ^ B));

endmodule : full_adder

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract controller. One full_adder cell is time-multiplexed
// across WIDTH operand bits, LSB first, with a registered carry between bits.
// Results (sum, cout, overflow) are published at the final RUN edge and held
// until the next operation completes; done pulses for one cycle.
module serial_adder_ctrl
  import serial_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic             fa_sum;
  logic             fa_cout;

  // The one shared adder cell: current LSBs of both operands plus the carry flop.
  full_adder u_full_adder (
    .A    (sa_q[0]),
    .B    (sb_q[0]),
    .Cin  (carry_q),
    .Sum  (fa_sum),
    .Cout (fa_cout)
  );

  // Next-state logic: FSM sequencing, operand load, bit shift and result publish.
  always_comb begin
    // NOTE: every _d signal gets a default here so no path through the case
    // leaves one unassigned, which would otherwise infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    res_d   = res_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        // DONE behaves like IDLE for start, so back-to-back requests are accepted.
        if (start) begin
          sa_d    = a;
          sb_d    = b ^ {WIDTH{sub}};  // subtract is A + ~B + 1
          carry_d = sub;
          cnt_d   = '0;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_RUN: begin
        res_d   = {fa_sum, res_q[WIDTH-1:1]};
        sa_d    = sa_q >> 1;
        sb_d    = sb_q >> 1;
        carry_d = fa_cout;
        if (cnt_q == CNT_LAST) begin
          // Carry into the MSB xor carry out of it flags signed overflow.
          sum_d   = {fa_sum, res_q[WIDTH-1:1]};
          cout_d  = fa_cout;
          ovf_d   = carry_q ^ fa_cout;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values,
    // independent of statement order.
    if (rst) begin
      // NOTE: the shift registers are cleared as well, so an aborted operation
      // leaves no stale operand or partial-result bits behind.
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sa_q    <= '0;
      sb_q    <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy     = (state_q == S_RUN);
  assign done     = (state_q == S_DONE);
  assign sum      = sum_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;

endmodule : serial_adder_ctrl

// File: tb/tb_serial_adder_ctrl.sv
// Directed testbench for serial_adder_ctrl (WIDTH=8). Inputs change on the
// falling edge; outputs are sampled on the falling edge.
module tb_serial_adder_ctrl;

  localparam int W       = 8;
  localparam int MAX_CYC = 50;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic         sub = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         overflow;

  int tests_run = 0;
  int tests_failed = 0;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .sub      (sub),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .cout     (cout),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  // Pulse start for one cycle with the given operands, then wait (bounded) for
  // done. lat counts falling edges from the start sample to the done sample;
  // nbusy counts the cycles busy was seen high; both_hi flags busy&&done.
  task automatic run_op(input logic [W-1:0] op_a, input logic [W-1:0] op_b,
                        input logic op_sub, output int lat, output int nbusy,
                        output bit both_hi);
    @(negedge clk);
    a = op_a; b = op_b; sub = op_sub; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1; nbusy = busy ? 1 : 0; both_hi = busy && done;
    while (!done && lat < MAX_CYC) begin
      @(negedge clk);
      lat++;
      if (busy) nbusy++;
      if (busy && done) both_hi = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    tests_run++;
    if ({busy, done, sum, cout, overflow} !== {1'b0, 1'b0, 8'h00, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL reset: busy=%b done=%b sum=%h cout=%b ovf=%b, want all 0",
               busy, done, sum, cout, overflow);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  // One add/sub operation against hand-computed results, latency and busy span.
  task automatic test_op(input string name, input logic [W-1:0] op_a,
                         input logic [W-1:0] op_b, input logic op_sub,
                         input logic [W-1:0] exp_sum, input logic exp_cout,
                         input logic exp_ovf);
    int lat, nbusy;
    bit both_hi;
    run_op(op_a, op_b, op_sub, lat, nbusy, both_hi);
    tests_run++;
    if (lat !== W + 1 || done !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s latency: got %0d done=%b, want %0d done=1", name, lat, done, W + 1);
    end
    tests_run++;
    if ({sum, cout, overflow} !== {exp_sum, exp_cout, exp_ovf}) begin
      tests_failed++;
      $display("FAIL %s result: sum=%h cout=%b ovf=%b, want sum=%h cout=%b ovf=%b",
               name, sum, cout, overflow, exp_sum, exp_cout, exp_ovf);
    end
    tests_run++;
    if (nbusy !== W || both_hi) begin
      tests_failed++;
      $display("FAIL %s busy: busy cycles=%0d overlap=%b, want %0d overlap=0",
               name, nbusy, both_hi, W);
    end
    // done is a single-cycle pulse; results hold in IDLE.
    repeat (2) @(negedge clk);
    tests_run++;
    if ({done, busy, sum, cout, overflow} !== {1'b0, 1'b0, exp_sum, exp_cout, exp_ovf}) begin
      tests_failed++;
      $display("FAIL %s hold: done=%b busy=%b sum=%h cout=%b ovf=%b, want done=0 busy=0 sum=%h cout=%b ovf=%b",
               name, done, busy, sum, cout, overflow, exp_sum, exp_cout, exp_ovf);
    end
  endtask

  task automatic test_busy_protect();
    int ndone;
    @(negedge clk);
    a = 8'h01; b = 8'h01; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    a = 8'hAA; b = 8'h55; start = 1'b1;   // mid-RUN request, must be ignored
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    for (int i = 0; i < 3 * W; i++) begin
      if (done) begin
        ndone++;
        tests_run++;
        if (sum !== 8'h02) begin
          tests_failed++;
          $display("FAIL busy_protect sum: got %h want 02", sum);
        end
      end
      @(negedge clk);
    end
    tests_run++;
    if (ndone !== 1) begin
      tests_failed++;
      $display("FAIL busy_protect done count: got %0d want 1", ndone);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    @(negedge clk);
    a = 8'h03; b = 8'h04; sub = 1'b0; start = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!done && n < MAX_CYC);
    tests_run++;
    if (n !== W + 1 || sum !== 8'h07) begin
      tests_failed++;
      $display("FAIL b2b first: cycles=%0d sum=%h, want %0d sum=07", n, sum, W + 1);
    end
    a = 8'h10; b = 8'h10;                 // switched during the DONE cycle
    n = 0;
    do begin @(negedge clk); n++; end while (!done && n < MAX_CYC);
    tests_run++;
    if (n !== W + 1 || sum !== 8'h20 || done !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b second: gap=%0d sum=%h done=%b, want gap %0d sum=20 done=1",
               n, sum, done, W + 1);
    end
    start = 1'b0;
    @(negedge clk);
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b stop: busy=%b done=%b, want 0 0", busy, done);
    end
  endtask

  task automatic test_reset_mid();
    int ndone;
    @(negedge clk);
    a = 8'hF0; b = 8'h33; sub = 1'b0; start = 1'b1;
    @(negedge clk);                       // RUN cycle 1
    start = 1'b0;
    repeat (3) @(negedge clk);            // now in RUN cycle 4
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_mid pre: busy=%b want 1", busy);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tests_run++;
    if ({busy, done, sum, cout, overflow} !== {1'b0, 1'b0, 8'h00, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL reset_mid: busy=%b done=%b sum=%h cout=%b ovf=%b, want all 0",
               busy, done, sum, cout, overflow);
    end
    ndone = 0;
    for (int i = 0; i < 2 * W; i++) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    tests_run++;
    if (ndone !== 0) begin
      tests_failed++;
      $display("FAIL reset_mid aborted: busy/done seen %0d cycles, want 0", ndone);
    end
    test_op("after_reset", 8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_op("add",       8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1);
    test_op("add_wrap",  8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    test_op("sub_borrow",8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0);
    test_op("sub_ovf",   8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);
    test_op("add_ovf_neg",8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
    test_busy_protect();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_serial_adder_ctrl
